multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op, input, 6, instruction opcode field from the instruction register.
REQ-004 SHALL have port func, input, 6, R-type function field from the instruction register.
REQ-005 SHALL have port Z, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory completes the current access in a cycle where it and MEMREQ are both 1.
REQ-007 SHALL have outputs PCWRITE, IRWRITE, MEMREQ, WMEM, M2REG, ALUIMM, SEXT, REGRT, WREG, JUMP, BRANCH, ILLEGAL, each 1 bit, with the existing datapath meanings; ILLEGAL flags an undecodable instruction.
REQ-008 SHALL have output ALUC, 4 bits: add 0000, sub 0001, and 0010, or 0011, slt 0100.
REQ-009 SHALL have output STATE, 3 bits: IDLE 000, IF 001, ID 010, EX 011, MEM 100, WB 101.

Function
REQ-010 SHALL sample op/func only in ID and latch the decoded class and ALUC; later changes to op/func SHALL NOT affect the instruction in flight.
REQ-011 SHALL use decoded classes: R-type (op 000000; func 100000/100010/100100/100101/101010), NOP (op 000000, func 000000), addi 001000, andi 001100, ori 001101, slti 001010 (ALUC as the matching R-type operation), lw 100011, sw 101011, j 000010; everything else SHALL be illegal.
REQ-012 SHALL drive outputs combinationally from STATE and the latched decode only; outputs not listed for a state SHALL be 0.
REQ-013 IDLE: all outputs 0; next state IF unconditionally.
REQ-014 IF: MEMREQ=1; hold while mem_ready=0; in the mem_ready=1 cycle drive IRWRITE=1 and PCWRITE=1 (PC+4), then go to ID.
REQ-015 ID: if illegal, ILLEGAL=1 for exactly this cycle and go to IF; if j, JUMP=1 and PCWRITE=1, then go to IF; if NOP, go to IF; otherwise go to EX.
REQ-016 EX: drive latched ALUC; ALUIMM=SEXT=1 for immediate, lw and sw; R-type and immediate go to WB; lw and sw go to MEM.
REQ-017 MEM: MEMREQ=1, ALUIMM=SEXT=1, ALUC=0000, WMEM=1 for sw only; hold while mem_ready=0; on mem_ready=1, lw goes to WB and sw goes to IF.
REQ-018 WB: WREG=1 for exactly one cycle; REGRT=1 for immediate and lw; M2REG=1 for lw only; next state IF.
REQ-019 Latency with mem_ready tied to 1, counted from IF entry to the next IF entry: j/NOP/illegal 2, R-type/immediate 4, sw 4, lw 5 cycles; each cycle of mem_ready=0 adds 1 cycle.
REQ-020 mem_ready while MEMREQ=0 SHALL be ignored.
REQ-021 WREG, WMEM, PCWRITE and IRWRITE SHALL each pulse at most once per instruction.

Reset
REQ-022 rst_n=0 SHALL immediately force STATE=IDLE and all outputs to 0, including in the middle of an instruction; the aborted instruction SHALL issue no further strobes.
REQ-023 The latched decode SHALL reset to NOP with ALUC=0000.
REQ-024 The first MEMREQ SHALL occur one clock after the first rising edge with rst_n=1.

Configuration
REQ-025 With macro MC_BEQ_EN defined, op 000100 (beq) SHALL decode as a branch: ID goes to EX; EX drives ALUC=0001 and BRANCH=1, drives PCWRITE=Z, and goes to IF (latency 3).
REQ-026 Without MC_BEQ_EN, op 000100 SHALL be treated as illegal per REQ-015, and BRANCH SHALL be constant 0.

Verification
REQ-027 Release reset with mem_ready=1 and op=000000, func=100000 -> STATE sequence IDLE,IF,ID,EX,WB; ALUC=0000 in EX; one WREG pulse in WB with REGRT=0; next IF at cycle 5.
REQ-028 lw (op 100011) with mem_ready=0 for 2 MEM cycles -> MEM lasts 3 cycles with MEMREQ=1 and WMEM=0; WB has WREG=1, M2REG=1, REGRT=1; total 7 cycles.
REQ-029 sw (op 101011) -> WMEM=1 only in the MEM cycle with mem_ready=1 and never WREG; returns to IF after 4 cycles.
REQ-030 op=111111 -> ILLEGAL=1 for one ID cycle and no WREG/WMEM/PCWRITE beyond IF; then IF. op=000010 -> JUMP=1 and PCWRITE=1 in ID.
REQ-031 With MC_BEQ_EN, beq with Z=1 -> BRANCH=1 and PCWRITE=1 in EX; with Z=0 -> PCWRITE=0. Without MC_BEQ_EN -> ILLEGAL=1.
REQ-032 Assert rst_n=0 during WB of addi -> WREG drops to 0 asynchronously, STATE=000; after release, restart at IF with no pending write.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for a multicycle MIPS-style datapath. A single state register
// steps through IDLE -> IF -> ID -> (EX -> (MEM) -> (WB)) -> IF. The
// instruction class and its ALU operation are latched at the end of ID, so
// later changes on op/func do not disturb the instruction in flight.
//
// Optional feature:
//   MC_BEQ_EN  - when defined, op 000100 decodes as beq (compare in EX, PC
//                written with the ALU zero flag). When undefined, op 000100 is
//                illegal and BRANCH never asserts.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   op         in   6  opcode field from the instruction register
//   func       in   6  R-type function field from the instruction register
//   Z          in   1  ALU zero flag
//   mem_ready  in   1  memory completes the access while MEMREQ=1
//   PCWRITE    out  1  PC write enable
//   IRWRITE    out  1  instruction register write enable
//   MEMREQ     out  1  memory access request
//   WMEM       out  1  memory write strobe
//   M2REG      out  1  register write data comes from memory
//   ALUIMM     out  1  ALU B operand is the immediate
//   SEXT       out  1  sign-extend the immediate
//   REGRT      out  1  destination register is rt
//   WREG       out  1  register file write strobe
//   JUMP       out  1  PC source is the jump target
//   BRANCH     out  1  PC source is the branch target
//   ILLEGAL    out  1  undecodable instruction (one ID cycle)
//   ALUC       out  4  ALU op: add 0000, sub 0001, and 0010, or 0011, slt 0100
//   STATE      out  3  IDLE 000, IF 001, ID 010, EX 011, MEM 100, WB 101
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       Z,
    input  logic       mem_ready,
    output logic       PCWRITE,
    output logic       IRWRITE,
    output logic       MEMREQ,
    output logic       WMEM,
    output logic       M2REG,
    output logic       ALUIMM,
    output logic       SEXT,
    output logic       REGRT,
    output logic       WREG,
    output logic       JUMP,
    output logic       BRANCH,
    output logic       ILLEGAL,
    output logic [3:0] ALUC,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_IF   = 3'b001,
        S_ID   = 3'b010,
        S_EX   = 3'b011,
        S_MEM  = 3'b100,
        S_WB   = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_RTYPE,
        C_IMM,
        C_LW,
        C_SW,
        C_J,
        C_BEQ,
        C_ILL
    } class_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    state_t     state;
    class_t     cls;        // latched instruction class
    logic [3:0] aluc_q;     // latched ALU operation

    class_t     dec_cls;    // live decode of op/func, only meaningful in ID
    logic [3:0] dec_aluc;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_cls  = C_ILL;
        dec_aluc = ALU_ADD;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000: begin dec_cls = C_RTYPE; dec_aluc = ALU_ADD; end
                    6'b100010: begin dec_cls = C_RTYPE; dec_aluc = ALU_SUB; end
                    6'b100100: begin dec_cls = C_RTYPE; dec_aluc = ALU_AND; end
                    6'b100101: begin dec_cls = C_RTYPE; dec_aluc = ALU_OR;  end
                    6'b101010: begin dec_cls = C_RTYPE; dec_aluc = ALU_SLT; end
                    6'b000000: dec_cls = C_NOP;
                    default:   dec_cls = C_ILL;
                endcase
            end
            6'b001000: begin dec_cls = C_IMM; dec_aluc = ALU_ADD; end
            6'b001100: begin dec_cls = C_IMM; dec_aluc = ALU_AND; end
            6'b001101: begin dec_cls = C_IMM; dec_aluc = ALU_OR;  end
            6'b001010: begin dec_cls = C_IMM; dec_aluc = ALU_SLT; end
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000010: dec_cls = C_J;
`ifdef MC_BEQ_EN
            6'b000100: begin dec_cls = C_BEQ; dec_aluc = ALU_SUB; end
`endif
            default:   dec_cls = C_ILL;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and latched decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cls    <= C_NOP;
            aluc_q <= ALU_ADD;
        end else begin
            case (state)
                S_IDLE: state <= S_IF;
                S_IF: begin
                    if (mem_ready) state <= S_ID;
                end
                S_ID: begin
                    cls    <= dec_cls;
                    aluc_q <= dec_aluc;
                    case (dec_cls)
                        C_ILL, C_J, C_NOP: state <= S_IF;
                        default:           state <= S_EX;
                    endcase
                end
                S_EX: begin
                    case (cls)
                        C_RTYPE, C_IMM: state <= S_WB;
                        C_LW, C_SW:     state <= S_MEM;
                        default:        state <= S_IF;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) state <= (cls == C_LW) ? S_WB : S_IF;
                end
                S_WB:    state <= S_IF;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. ID uses the live decode because the class is only
    // latched at the end of that cycle; all later states use the latch.
    // mem_ready gates the single-cycle strobes so a held access still
    // produces exactly one IRWRITE/PCWRITE or WMEM pulse.
    // ------------------------------------------------------------------
    always_comb begin
        PCWRITE = 1'b0;
        IRWRITE = 1'b0;
        MEMREQ  = 1'b0;
        WMEM    = 1'b0;
        M2REG   = 1'b0;
        ALUIMM  = 1'b0;
        SEXT    = 1'b0;
        REGRT   = 1'b0;
        WREG    = 1'b0;
        JUMP    = 1'b0;
        BRANCH  = 1'b0;
        ILLEGAL = 1'b0;
        ALUC    = ALU_ADD;
        case (state)
            S_IF: begin
                MEMREQ  = 1'b1;
                IRWRITE = mem_ready;
                PCWRITE = mem_ready;
            end
            S_ID: begin
                ILLEGAL = (dec_cls == C_ILL);
                JUMP    = (dec_cls == C_J);
                PCWRITE = (dec_cls == C_J);
            end
            S_EX: begin
                ALUC   = aluc_q;
                ALUIMM = (cls == C_IMM) || (cls == C_LW) || (cls == C_SW);
                SEXT   = (cls == C_IMM) || (cls == C_LW) || (cls == C_SW);
                BRANCH = (cls == C_BEQ);
                PCWRITE = (cls == C_BEQ) && Z;
            end
            S_MEM: begin
                MEMREQ = 1'b1;
                ALUIMM = 1'b1;
                SEXT   = 1'b1;
                WMEM   = (cls == C_SW) && mem_ready;
            end
            S_WB: begin
                WREG  = 1'b1;
                REGRT = (cls == C_IMM) || (cls == C_LW);
                M2REG = (cls == C_LW);
            end
            default: ;
        endcase
    end

    assign STATE = state;

endmodule
